// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-side loader and the core's control unit.
// Holds the loader FSM encoding, default instruction width and the NOP word.
// Also provides the fetch range check used by the responder.
package inst_mem_loader_pkg;

  // Loader FSM encoding, shared with the core's control unit
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_LOAD_WR = 2'd2
  } ldr_state_t;

  // Instruction width expected by the core
  localparam int DATA_W_DEF = 16;

  // Width of the PC the core presents on a fetch
  localparam int FETCH_ADDR_W = 12;

  // Instruction returned for out-of-range fetches
  localparam logic [DATA_W_DEF-1:0] INST_NOP = 16'h0000;

  // True when any PC bit above the memory's address range is set
  function automatic logic fetch_oob(input logic [FETCH_ADDR_W-1:0] addr,
                                     input int                      addr_w);
    return (addr >> addr_w) != '0;
  endfunction

endpackage

// File: rtl/inst_mem_loader_key_debouncer.sv
// Purpose: synchronise and debounce one active-low pushbutton; pulse on each accepted press.
// Latency: press_strobe 2 + DEBOUNCE_CYCLES + 1 cycles after a clean key_n fall.
// Backpressure: none; press_strobe is a single-cycle pulse with no handshake.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press_strobe
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             key_meta;
  logic             key_sync;
  logic             key_level;
  logic [CNT_W-1:0] stable_cnt;

  // Two-flop synchroniser; idles at the released level so reset never looks like a press
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Count how long the synced key has disagreed with the accepted level; accept after the window
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_level    <= 1'b1;
      stable_cnt   <= '0;
      press_strobe <= 1'b0;
    end else begin
      press_strobe <= 1'b0;
      if (key_sync == key_level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_MAX) begin
        key_level    <= key_sync;
        stable_cnt   <= '0;
        // only the falling (press) transition is reported
        press_strobe <= ~key_sync;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Purpose: instruction memory answering core fetches; in load mode, writes switch words on key presses.
// Latency: fetch response one cycle after fetch_req; key write 2 + DEBOUNCE_CYCLES + 3 cycles after press.
// Backpressure: none; RUN accepts a fetch every cycle, load states silently drop fetches.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    load_mode,
  input  logic [DATA_W-1:0]       sw_data,
  input  logic                    key_n,
  input  logic                    fetch_req,
  input  logic [FETCH_ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0]       inst,
  output logic                    inst_valid,
  output logic                    addr_err,
  output logic [ADDR_W-1:0]       load_ptr,
  output logic                    full,
  output logic                    overflow
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  ldr_state_t state;
  ldr_state_t state_nxt;

  logic wr_strobe;
  logic mem_we;
  logic ptr_clr;
  logic ptr_adv;
  logic ovf_set;
  logic fetch_vld;
  logic fetch_err;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .key_n       (key_n),
    .press_strobe(wr_strobe)
  );

  assign fetch_err = fetch_oob(fetch_addr, ADDR_W);

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    ptr_clr   = 1'b0;
    ptr_adv   = 1'b0;
    ovf_set   = 1'b0;
    fetch_vld = 1'b0;
    unique case (state)
      ST_RUN: begin
        // a fetch in the last RUN cycle is still honoured
        fetch_vld = fetch_req;
        if (load_mode) begin
          state_nxt = ST_LOAD;
          ptr_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!load_mode) begin
          state_nxt = ST_RUN;
        end else if (wr_strobe) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            state_nxt = ST_LOAD_WR;
          end
        end
      end
      ST_LOAD_WR: begin
        // a started write always completes, even if load_mode has dropped
        mem_we    = 1'b1;
        ptr_adv   = 1'b1;
        state_nxt = load_mode ? ST_LOAD : ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // State register and load-pointer bookkeeping
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_RUN;
      load_ptr <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ptr_clr) begin
        load_ptr <= '0;
        full     <= 1'b0;
        overflow <= 1'b0;
      end
      if (ptr_adv) begin
        // pointer parks on the last word once it has been written
        if (load_ptr == PTR_LAST) begin
          full <= 1'b1;
        end else begin
          load_ptr <= load_ptr + ADDR_W'(1);
        end
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  // RAM write port; contents survive reset but a write coinciding with reset is dropped
  always_ff @(posedge CLOCK_50) begin
    if (mem_we && !reset) begin
      mem[load_ptr] <= sw_data;
    end
  end

  // Registered fetch response; inst holds between fetches, valid/err are pulses
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      inst_valid <= fetch_vld;
      addr_err   <= fetch_vld && fetch_err;
      if (fetch_vld) begin
        inst <= fetch_err ? DATA_W'(INST_NOP) : mem[fetch_addr[ADDR_W-1:0]];
      end
    end
  end

endmodule
